uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter BRUST_SIZE_LOG, default 2, giving log2 of the bytes per burst (burst = 2^BRUST_SIZE_LOG bytes).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the byte width carried to the UART transmitter.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; it SHALL have no other clock or reset.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req0_valid  input  1  requester 0 has a byte available.
REQ-007 req0_data  input  DATA_WIDTH  requester 0 byte.
REQ-008 req0_ready  output  1  arbiter accepts the req0 byte this cycle.
REQ-009 req1_valid / req1_data / req1_ready  same widths, directions and meaning as requester 0.
REQ-010 send_start  output  1  one-cycle pulse starting one UART transmission.
REQ-011 send_data  output  DATA_WIDTH  byte to transmit; stable from the send_start cycle until send_finish is seen.
REQ-012 send_finish  input  1  UART transmitter reports that the current byte is done.
REQ-013 grant  output  2  one-hot owner of the channel (bit i = requester i); 2'b00 when idle.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, START and WAIT.
REQ-016 IDLE: if any reqX_valid is high, it SHALL set grant and move to LOAD on the next cycle; otherwise it SHALL stay in IDLE.
REQ-017 When only one requester is valid in IDLE, that requester SHALL be granted.
REQ-018 When both requesters are valid in IDLE, the requester not granted last SHALL win (round-robin).
REQ-019 A last_grant register SHALL record the last winner; its reset value SHALL be requester 1, so requester 0 wins the first tie.
REQ-020 reqX_ready SHALL equal (state==LOAD) AND grant[X], decoded from registered state only; the ready of the non-granted requester SHALL stay 0.
REQ-021 LOAD: when the granted valid and ready are both high, the block SHALL capture reqX_data into send_data and move to START.
REQ-022 LOAD: while the granted valid is low, the block SHALL stay in LOAD indefinitely, with no timeout and grant held.
REQ-023 START: send_start SHALL be 1 for exactly this cycle, then the block SHALL move to WAIT.
REQ-024 WAIT: the block SHALL hold until send_finish is 1.
REQ-025 On send_finish in WAIT, the byte counter (BRUST_SIZE_LOG bits) SHALL increment. If the pre-increment count equals 2^BRUST_SIZE_LOG-1, the block SHALL go to IDLE, clear grant, write last_grant and let the counter wrap to 0. Otherwise it SHALL go to LOAD with grant unchanged.
REQ-026 send_finish SHALL be ignored in every state other than WAIT.
REQ-027 A burst SHALL never be interleaved: the other requester's valid SHALL have no effect until the block returns to IDLE.
REQ-028 Latency: with valid at cycle t in IDLE, the byte SHALL be accepted at t+1 and send_start SHALL pulse at t+2.
REQ-029 Latency: with send_finish at cycle f (not the last byte), ready SHALL be asserted again at f+1.
REQ-030 Minimum back-to-back burst gap: IDLE occupies exactly one cycle between two bursts when a requester is already valid.

Reset
REQ-031 While rst is 1, state SHALL be IDLE; grant, send_start, req0_ready, req1_ready and busy SHALL be 0; send_data and the counter SHALL be 0; last_grant SHALL be requester 1.
REQ-032 Reset asserted mid-burst SHALL abandon the burst; no further send_start SHALL be issued for it, and a send_finish arriving after reset SHALL be ignored.

Verification
REQ-033 Scenario 1: req0_valid=1 only, data 0x11,0x22,0x33,0x44, finish 10 cycles after each start -> 4 send_start pulses with send_data 0x11,0x22,0x33,0x44; grant=01 throughout; then IDLE.
REQ-034 Scenario 2: both valid from reset -> burst 1 on requester 0 and burst 2 on requester 1, in strict alternation; no byte of one requester between bytes of the other.
REQ-035 Scenario 3: req0_valid drops for 5 cycles after byte 2 -> block holds in LOAD with grant=01 and send_start=0, then resumes with byte 3.
REQ-036 Scenario 4: send_finish pulsed in IDLE, LOAD and START -> no state change and the counter is unchanged.
REQ-037 Scenario 5: rst asserted during WAIT of byte 3 -> next cycle all outputs 0 and state IDLE; the following burst starts at count 0 and req0 wins a tie.
REQ-038 Scenario 6: send_data checked against its captured value on every cycle from send_start through send_finish -> no change.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a UART transmitter in bursts of
// 2^BRUST_SIZE_LOG bytes; a burst is never interleaved with the other requester.
module uart_tx_arbiter #(
  parameter int BRUST_SIZE_LOG = 2,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  send_start,
  output logic [DATA_WIDTH-1:0] send_data,
  input  logic                  send_finish,
  output logic [1:0]            grant,
  output logic                  busy
);

  localparam int                CNT_W    = (BRUST_SIZE_LOG > 0) ? BRUST_SIZE_LOG : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << BRUST_SIZE_LOG) - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    WAIT
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            grant_nxt;
  logic                  last_grant, last_grant_nxt;  // 1 = requester 1 won last
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] send_data_nxt;
  logic                  accept;

  // Handshake outputs decode registered state only, never the valids.
  assign req0_ready = (state == LOAD) && grant[0];
  assign req1_ready = (state == LOAD) && grant[1];
  assign send_start = (state == START);
  assign busy       = (state != IDLE);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 1'b1;
      cnt        <= '0;
      send_data  <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      send_data  <= send_data_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    send_data_nxt  = send_data;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_nxt = LOAD;
          if (req0_valid && req1_valid)
            grant_nxt = last_grant ? 2'b01 : 2'b10;
          else
            grant_nxt = req0_valid ? 2'b01 : 2'b10;
        end
      end
      LOAD: begin
        if (accept) begin
          send_data_nxt = grant[1] ? req1_data : req0_data;
          state_nxt     = START;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (send_finish) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            // Burst done: release the channel and remember who owned it.
            state_nxt      = IDLE;
            grant_nxt      = '0;
            last_grant_nxt = grant[1];
            cnt_nxt        = '0;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a flag-based transaction model
// of owner / pending byte / pending start / byte in flight.
module tb_uart_tx_arbiter;

  localparam int LOG   = 2;
  localparam int BURST = 1 << LOG;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       send_start;
  logic [7:0] send_data;
  logic       send_finish;
  logic [1:0] grant;
  logic       busy;

  uart_tx_arbiter #(.BRUST_SIZE_LOG(LOG), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .send_start (send_start),
    .send_data  (send_data),
    .send_finish(send_finish),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: owner -1 = channel free; m_wait = byte requested, m_start = start
  // pulse due, m_fly = byte on the wire; m_sent = bytes finished this burst.
  int         m_owner;
  int         m_last;
  bit         m_wait, m_start, m_fly;
  int         m_sent;
  logic [7:0] m_data;

  logic [9:0] starts[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1, input logic fin);
    logic [1:0] exp_grant;
    rst = r; req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1; send_finish = fin;
    if (r) begin
      m_owner = -1; m_last = 1; m_wait = 0; m_start = 0; m_fly = 0;
      m_sent = 0; m_data = '0;
    end else if (m_owner < 0) begin
      if (v0 || v1) begin
        m_owner = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
        m_wait  = 1;
      end
    end else if (m_wait) begin
      if ((m_owner == 0) ? v0 : v1) begin
        m_data  = (m_owner == 0) ? d0 : d1;
        m_wait  = 0;
        m_start = 1;
      end
    end else if (m_start) begin
      m_start = 0;
      m_fly   = 1;
    end else if (m_fly && fin) begin
      m_fly = 0;
      m_sent++;
      if (m_sent == BURST) begin
        m_last  = m_owner;
        m_owner = -1;
        m_sent  = 0;
      end else begin
        m_wait = 1;
      end
    end
    @(posedge clk);
    #1;
    exp_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    check("grant",      32'(grant),      32'(exp_grant));
    check("req0_ready", 32'(req0_ready), 32'(m_wait && m_owner == 0));
    check("req1_ready", 32'(req1_ready), 32'(m_wait && m_owner == 1));
    check("send_start", 32'(send_start), 32'(m_start));
    check("busy",       32'(busy),       32'(m_owner >= 0));
    check("send_data",  32'(send_data),  32'(m_data));
    if (send_start) starts.push_back({grant, send_data});
  endtask

  initial begin
    logic [7:0] pat [4];
    int         idx, wcnt, cyc;
    bit         fin;
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; send_finish = 1'b0;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 8'hAA, 1, 8'hBB, 1);

    // Directed burst from requester 0 only, finish 10 cycles after each start.
    starts.delete();
    idx = 0; wcnt = 0; cyc = 0;
    while (!(idx == BURST && m_owner < 0) && cyc < 400) begin
      fin = m_fly && (wcnt == 9);
      if (m_wait && m_owner == 0) begin
        tick(0, 1, pat[idx], 0, 8'h00, 0);
        idx++;
      end else begin
        tick(0, idx < BURST, (idx < BURST) ? pat[idx] : 8'h00, 0, 8'h00, fin);
      end
      wcnt = m_fly ? wcnt + 1 : 0;
      cyc++;
    end
    check("s1_done", 32'(cyc < 400), 32'd1);
    check("s1_nbytes", 32'(starts.size()), 32'd4);
    for (int i = 0; i < 4 && i < starts.size(); i++)
      check("s1_byte", 32'(starts[i]), 32'({2'b01, pat[i]}));

    // Randomized traffic with occasional mid-burst resets.
    for (int n = 0; n < 4000; n++) begin
      tick($urandom_range(0, 249) == 0,
           $urandom_range(0, 9) < 7, 8'($urandom),
           $urandom_range(0, 9) < 6, 8'($urandom),
           $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
